// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// One hex digit is shown per slot, and each slot starts with an all-anodes-off
// blank gap to prevent ghosting. New values are double-buffered: load writes a
// shadow register, which is copied to the display register only at a frame
// boundary (or straight away while idle), so a frame never mixes old and new data.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (outputs go dark immediately)
//   enable     scan enable; 0 forces IDLE with dark outputs
//   value      hex digits, digit k = value[4k+3:4k]
//   dp_in      decimal point request per digit (1 = lit)
//   load       single-cycle strobe capturing value/dp_in into the shadow
//   seg        segments {a..g}, seg[6]=a, active-low, registered
//   dp         decimal point, active-low, registered
//   an         anode selects, active-low, at most one low, registered
//   frame_done one-cycle pulse on the first BLANK cycle of each new frame
//
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN
//   When defined, leading zeros above the most significant nonzero digit are
//   blanked (digit 0 is never blanked; dp still follows dp_in).
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val, disp_val_nx;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, disp_dp_nx;
  logic                    pending, pending_nx;
  logic                    wrap;
  logic                    commit_load, commit_pend;
  logic [6:0]              seg_nx;
  logic                    dp_nx;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      4'hF: return 7'b0111000;
    endcase
  endfunction

  // State, counters, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      disp_val <= disp_val_nx;
      disp_dp  <= disp_dp_nx;
      pending  <= pending_nx;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      seg        <= seg_nx;
      dp         <= dp_nx;
      an         <= an_nx;
      frame_done <= wrap;
    end
  end

  // Next-state logic: slot sequencing plus display-register commit.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    wrap     = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        BLANK: begin
          // cnt runs across the whole slot; the blank gap is its first part.
          cnt_nx = cnt + CW'(1);
          if (cnt == BLANK_LAST) state_nx = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            if (idx == IDX_LAST) begin
              idx_nx = '0;
              wrap   = 1'b1;
            end else begin
              idx_nx = idx + IW'(1);
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // A load in the boundary cycle or in the frame_done cycle still lands in
    // the new frame: digit 0 is blanked during both, so nothing tears.
    commit_load = load && ((state == IDLE) || (enable && (wrap || frame_done)));
    commit_pend = pending && ((state == IDLE) || wrap);
    disp_val_nx = disp_val;
    disp_dp_nx  = disp_dp;
    pending_nx  = pending;
    if (commit_load) begin
      disp_val_nx = value;
      disp_dp_nx  = dp_in;
      pending_nx  = 1'b0;
    end else if (commit_pend) begin
      disp_val_nx = shadow_val;
      disp_dp_nx  = shadow_dp;
      pending_nx  = 1'b0;
    end else if (load) begin
      pending_nx = 1'b1;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] nib_nz;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib_nz
    assign nib_nz[gi] = |disp_val_nx[4*gi +: 4];
  end

  // Scan from the top digit down; everything above the first nonzero nibble
  // is blanked. Digit 0 is left out of the scan so it always shows.
  always_comb begin : lz_scan
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      seen        = seen | nib_nz[k];
      lz_blank[k] = ~seen;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Output decode from next-state values so the registered outputs line up
  // with the state register (no extra cycle of lag).
  always_comb begin
    cur_nib = disp_val_nx[{idx_nx, 2'b00} +: 4];
    seg_nx  = 7'h7F;
    dp_nx   = 1'b1;
    an_nx   = '1;
    if (state_nx != IDLE) begin
      seg_nx = lz_blank[idx_nx] ? 7'h7F : hex7(cur_nib);
      dp_nx  = ~disp_dp_nx[idx_nx];
      if (state_nx == SHOW) an_nx[idx_nx] = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2).
// The reference model tracks time since the scan started and derives digit,
// blank/show phase and frame boundaries arithmetically from that count.
module tb_seg_scan_driver;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int B     = 2;
  localparam int FRAME = N * DIV;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] value  = 16'h0;
  logic [3:0]  dp_in  = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  logic [6:0] dec_tab [16];

  // Reference model state.
  logic        m_running;
  int          m_t;
  logic        m_fd;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_ddp, m_sdp;
  logic        m_pend;

  seg_scan_driver #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .load(load), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_running = 1'b0; m_t = 0; m_fd = 1'b0;
    m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
    logic prev_fd;
    prev_fd = m_fd;
    if (ld) begin m_shadow = v; m_sdp = d; end
    if (!m_running) begin
      // Idle: loads and any pending data go straight to the display.
      if (ld) begin m_disp = v; m_ddp = d; m_pend = 1'b0; end
      else if (m_pend) begin m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0; end
      m_running = en; m_t = 0; m_fd = 1'b0;
    end else if (!en) begin
      if (ld) m_pend = 1'b1;
      m_running = 1'b0; m_t = 0; m_fd = 1'b0;
    end else begin
      m_t  = m_t + 1;
      m_fd = (m_t % FRAME) == 0;
      if (m_fd && (ld || m_pend)) begin
        m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
      end else if (prev_fd && ld) begin
        m_disp = v; m_ddp = d; m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
    end
  endtask

  // Expected {an, seg, dp, frame_done} for the current model state.
  function automatic logic [12:0] model_out();
    int         dg, pos;
    logic [3:0] an_e, nib;
    logic [6:0] s;
    if (!m_running) return {4'hF, 7'h7F, 1'b1, 1'b0};
    dg   = (m_t / DIV) % N;
    pos  = m_t % DIV;
    an_e = (pos < B) ? 4'hF : ~(4'b0001 << dg);
    nib  = 4'((m_disp >> (4*dg)) & 16'hF);
    s    = dec_tab[nib];
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (dg > 0 && (m_disp >> (4*dg)) == 16'h0) s = 7'h7F;
`endif
    return {an_e, s, ~m_ddp[dg], m_fd};
  endfunction

  // Drive inputs for one cycle, advance model at the edge, settle 1 time unit.
  task automatic step(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
    enable = en; load = ld; value = v; dp_in = d;
    @(posedge clk);
    model_edge(en, ld, v, d);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] want;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0", an, seg, dp, frame_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0, 4'h0);
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL reset_idle: got %b expected %b", {an, seg, dp, frame_done}, want);
      end
    end
    $display("reset: idle after release checked");
  endtask

  task automatic test_scan();
    logic [12:0] want;
    logic [6:0]  seq [4];
    int          dg;
    seq[0] = 7'b0111000; seq[1] = 7'b0001000; seq[2] = 7'b0010010; seq[3] = 7'b1001111;
    step(1'b0, 1'b1, 16'h12AF, 4'h0);
    $display("load value=12af dp=0000 (idle)");
    for (int i = 0; i < FRAME + 4; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL scan t=%0d: got %b expected %b", m_t, {an, seg, dp, frame_done}, want);
      end
      dg = (m_t / DIV) % N;
      if (m_t < FRAME && (m_t % DIV) >= B) begin
        total++;
        if (seg !== seq[dg] || an !== ~(4'b0001 << dg)) begin
          bad++;
          $display("FAIL scan_seq t=%0d: got an=%b seg=%b expected an=%b seg=%b", m_t, an, seg, ~(4'b0001 << dg), seq[dg]);
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [12:0] want;
    for (int i = 0; i < 2*FRAME && (m_t % FRAME) != 10; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h0008, 4'h0);
    $display("load value=0008 dp=0000 (mid-frame t=%0d)", m_t);
    for (int i = 0; i < 2*FRAME; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL midframe t=%0d: got %b expected %b", m_t, {an, seg, dp, frame_done}, want);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [12:0] want;
    logic [15:0] v;
    // Load on the frame_done cycle, then on the last SHOW cycle before a boundary.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2*FRAME; i++) begin
        if (pass == 0 && m_fd) break;
        if (pass == 1 && (m_t % FRAME) == FRAME - 1) break;
        step(1'b1, 1'b0, 16'h0, 4'h0);
      end
      v = 16'($urandom);
      step(1'b1, 1'b1, v, 4'($urandom));
      $display("load value=%h at boundary pass %0d", v, pass);
      for (int i = 0; i < FRAME; i++) begin
        step(1'b1, 1'b0, 16'h0, 4'h0);
        want = model_out();
        total++;
        if ({an, seg, dp, frame_done} !== want) begin
          bad++;
          $display("FAIL boundary%0d t=%0d: got %b expected %b", pass, m_t, {an, seg, dp, frame_done}, want);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [12:0] want;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (((m_t / DIV) % N) == 2 && (m_t % DIV) == B + 1) break;
      step(1'b1, 1'b0, 16'h0, 4'h0);
    end
    step(1'b0, 1'b0, 16'h0, 4'h0);
    total++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      bad++;
      $display("FAIL enable_drop: got an=%b seg=%b expected an=1111 seg=1111111", an, seg);
    end
    $display("enable dropped during digit 2 show");
    for (int i = 0; i < 14; i++) begin
      step(i >= 2, 1'b0, 16'h0, 4'h0);
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL reenable i=%0d: got %b expected %b", i, {an, seg, dp, frame_done}, want);
      end
    end
  endtask

  task automatic test_lz();
    logic [12:0] want;
    step(1'b0, 1'b1, 16'h0050, 4'b1000);
    $display("load value=0050 dp=1000 (idle)");
    for (int i = 0; i < FRAME + 2; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL lz t=%0d: got %b expected %b", m_t, {an, seg, dp, frame_done}, want);
      end
      if (m_t == 3*DIV + B) begin
        total++;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (seg !== 7'h7F || dp !== 1'b0) begin
          bad++;
          $display("FAIL lz_digit3: got seg=%b dp=%b expected seg=1111111 dp=0", seg, dp);
        end
`else
        if (seg !== 7'b0000001 || dp !== 1'b0) begin
          bad++;
          $display("FAIL lz_digit3: got seg=%b dp=%b expected seg=0000001 dp=0", seg, dp);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] want;
    logic        en, ld;
    logic [15:0] v;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 49) != 0);
      ld = ($urandom_range(0, 19) == 0);
      v  = 16'($urandom);
      if (ld) $display("load value=%h en=%0d (random cycle %0d)", v, en, i);
      step(en, ld, v, 4'($urandom));
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL random i=%0d: got %b expected %b", i, {an, seg, dp, frame_done}, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] want;
    for (int i = 0; i < 2*FRAME && !(m_running && (m_t % DIV) >= B); i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b fd=%b expected dark", an, seg, dp, frame_done);
    end
    $display("async reset asserted mid-show");
    model_reset();
    enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(i >= 5, 1'b0, 16'h0, 4'h0);
      want = model_out();
      total++;
      if ({an, seg, dp, frame_done} !== want) begin
        bad++;
        $display("FAIL post_reset i=%0d: got %b expected %b", i, {an, seg, dp, frame_done}, want);
      end
    end
  endtask

  initial begin
    dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    test_reset();
    test_scan();
    test_midframe_load();
    test_boundary_load();
    test_enable_drop();
    test_lz();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Scans one hex digit per slot, with per-digit decimal points and an anti-ghosting blank gap before each slot.
- Display updates are tear-free: new values are committed only at frame boundaries.
- Sits between the numeric datapath and the board display pins, and generalises the single-digit combinational hex decoder to a parametrised, scanned, registered block.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..16).
- DIV, 50000: clock cycles per digit slot, blank gap included; must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off (≥1).

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; 0 turns the display dark.
- value  in  4*NUM_DIGITS  hex digits; digit k = value[4k+3:4k]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  single-cycle strobe; captures value and dp_in into the shadow register.
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode selects, active-low, one-hot-low or all-high.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Decode (abcdefg, active-low):**
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
  - Blanked digit: 1111111.
- **Registers:**
  - shadow (value, dp) plus a pending flag; display register; digit index idx; slot counter cnt.
- **FSM states:**
  - IDLE: an all 1, seg 7'h7F, dp 1, idx=0, cnt=0.
    - Goes to BLANK when enable=1.
  - BLANK: an all 1; seg/dp pre-driven with the pattern for idx.
    - After BLANK_CYCLES cycles, goes to SHOW.
  - SHOW: an[idx]=0; seg/dp show the digit.
    - After DIV-BLANK_CYCLES cycles, goes to BLANK.
    - idx increments at that transition; when idx=NUM_DIGITS-1 it wraps to 0 instead (frame boundary).
- **Frame boundary:**
  - frame_done pulses for the first cycle of the new frame's BLANK.
  - If pending=1, shadow is copied to the display register and pending clears.
- **load:**
  - Sets shadow and pending.
  - A load on the exact boundary cycle is committed at that boundary; it is not deferred a frame.
  - In IDLE, load commits to the display register on the next cycle.
- **enable=0 in any state:** next cycle is IDLE with outputs dark; a pending commit is kept.
- **Registered outputs:** all outputs are registered; the decode is a function of the display register and idx.
- **Reset values:**
  - seg=7'h7F, dp=1, an=all 1, frame_done=0.
  - State IDLE, idx=0, cnt=0, shadow/display=0, pending=0.
  - Reset mid-slot darkens the outputs asynchronously.

## Timing
- Slot = DIV cycles; frame = NUM_DIGITS*DIV cycles; at most one anode is ever low.
- enable rise → first anode low after 1+BLANK_CYCLES cycles (digit 0).
- load → new data visible at the SHOW of digit 0 in the next frame; worst case ≈ 1 frame + BLANK_CYCLES.
- NUM_DIGITS=1: every slot end is a frame boundary; frame_done pulses every DIV cycles.
- Between any two digits, an is all-high for exactly BLANK_CYCLES cycles.

## Configuration
- **Macro:** SEG_SCAN_LZ_BLANK_EN.
- **Defined:**
  - Leading-zero suppression is applied to the display register: every digit above the most significant nonzero nibble shows 1111111.
  - Digit 0 is never blanked (value 0 displays "0").
  - dp is still driven from dp_in for blanked digits.
- **Undefined:** all digits always decode, including leading zeros.

## Test plan
- Reset, enable=1, DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4, load value=16'h12AF → an cycles 1110,1101,1011,0111 for 6 cycles each, separated by 2-cycle 1111 gaps; seg sequence 0111000, 0001000, 0010010, 1001111.
- Mid-frame load 16'h0008 → the current frame still shows 12AF; from the next frame digit 0 shows 0000000 and frame_done pulses at the switch.
- load asserted on the frame_done cycle → committed at that boundary, not one frame later.
- enable dropped during SHOW of digit 2 → next cycle an=1111, seg=7'h7F; re-enable → restarts at digit 0 after a 2-cycle blank.
- With SEG_SCAN_LZ_BLANK_EN, value=16'h0050, dp_in=4'b1000 → digit 3 shows seg 1111111 with dp=0, digit 2 is blank, digits 1/0 show 5/0. Without the macro, digits 3 and 2 show 0000001.
- rst_n asserted mid-SHOW → outputs dark immediately; after release the block stays in IDLE until enable.
